alu_arbiter: RTL and testbench

Round-robin arbiter that shares one `alu` instance between `REQN` requesters, such as CPU cores, a DMA engine and a debug port. Each requester presents an operation with two operands under a valid/ready handshake. The granted operation is computed by the shared `alu` and returned through a single registered response port tagged with the requester ID. The block sits between the register files of the requesting units and the arithmetic datapath.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu.sv | 35 +++
 rtl/rr_pick.sv | 43 ++++
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op encodings, default width
// and the arbiter FSM state type. The LOCKED_* states only exist when
// ALU_ARB_LOCK_EN is defined.
package alu_pkg;

    localparam int ALU_W_DEFAULT = 16;

    // 3-bit op codes understood by alu; the arbiter forwards them untouched.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_PASS = 3'd7;

`ifdef ALU_ARB_LOCK_EN
    typedef enum logic [1:0] {
        ST_EMPTY        = 2'd0,
        ST_FULL         = 2'd1,
        ST_LOCKED_EMPTY = 2'd2,
        ST_LOCKED_FULL  = 2'd3
    } arb_state_e;
`else
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;
`endif

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared by all requesters. ADD/SUB wrap modulo
// 2^N; shifts use the low log2(N) bits of rhs; op 7 passes lhs through.
module alu
    import alu_pkg::*;
#(
    parameter int N = ALU_W_DEFAULT
) (
    input  logic [2:0]   op,
    input  logic [N-1:0] lhs,
    input  logic [N-1:0] rhs,
    output logic [N-1:0] result
);

    localparam int SHW = (N > 1) ? $clog2(N) : 1;

    logic [SHW-1:0] shamt;

    assign shamt = rhs[SHW-1:0];

    // Evaluate the selected operation; the result truncates to N bits.
    always_comb begin
        result = lhs;
        case (op)
            ALU_ADD: result = lhs + rhs;
            ALU_SUB: result = lhs - rhs;
            ALU_AND: result = lhs & rhs;
            ALU_OR:  result = lhs | rhs;
            ALU_XOR: result = lhs ^ rhs;
            ALU_SLL: result = lhs << shamt;
            ALU_SRL: result = lhs >> shamt;
            default: result = lhs;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: grants the first set bit of req found
// scanning upward from ptr, wrapping from REQN-1 back to 0.
module rr_pick #(
    parameter int REQN = 4,
    parameter int IDW  = $clog2(REQN)
) (
    input  logic [REQN-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [REQN-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // Requests at or above the pointer take priority over those below it.
    logic [REQN-1:0] hi_req;
    logic [REQN-1:0] sel;

    generate
        for (genvar gi = 0; gi < REQN; gi++) begin : g_hi
            assign hi_req[gi] = req[gi] && (IDW'(gi) >= ptr);
        end
    endgenerate

    assign any = |req;
    assign sel = (|hi_req) ? hi_req : req;

    // Lowest set bit of the selected vector is the winner.
    always_comb begin
        gnt_id = '0;
        for (int i = REQN - 1; i >= 0; i--) begin
            if (sel[i]) begin
                gnt_id = IDW'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < REQN; gi++) begin : g_grant
            assign grant[gi] = any && (gnt_id == IDW'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between REQN requesters, with a single
// registered response port tagged by requester ID.
// Optional feature: define ALU_ARB_LOCK_EN to let a requester hold the grant
// across several ops via req_lock; otherwise req_lock is ignored.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N    = ALU_W_DEFAULT,
    parameter int REQN = 4,
    parameter int IDW  = $clog2(REQN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REQN-1:0]     req_valid,
    output logic [REQN-1:0]     req_ready,
    input  logic [3*REQN-1:0]   req_op,
    input  logic [N*REQN-1:0]   req_lhs,
    input  logic [N*REQN-1:0]   req_rhs,
    input  logic [REQN-1:0]     req_lock,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [N-1:0]        rsp_result,
    output logic                busy
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [N-1:0]    result_q, result_d;

    logic [2:0]      op_v  [REQN];
    logic [N-1:0]    lhs_v [REQN];
    logic [N-1:0]    rhs_v [REQN];

    logic [REQN-1:0] pick_req;
    logic [REQN-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  ptr_inc;
    logic            pick_any;
    logic            full;
    logic            slot_free;
    logic            accept;
    logic [N-1:0]    alu_y;

    // Split the flat request buses into per-requester fields.
    generate
        for (genvar gi = 0; gi < REQN; gi++) begin : g_slice
            assign op_v[gi]  = req_op[3*gi +: 3];
            assign lhs_v[gi] = req_lhs[N*gi +: N];
            assign rhs_v[gi] = req_rhs[N*gi +: N];
        end
    endgenerate

`ifdef ALU_ARB_LOCK_EN
    // While locked, ptr holds the owner and only the owner may compete.
    logic            locked;
    logic            take_lock;
    logic [REQN-1:0] owner_mask;

    generate
        for (genvar gi = 0; gi < REQN; gi++) begin : g_owner
            assign owner_mask[gi] = (ptr_q == IDW'(gi));
        end
    endgenerate

    assign full      = (state_q == ST_FULL) || (state_q == ST_LOCKED_FULL);
    assign locked    = (state_q == ST_LOCKED_EMPTY) || (state_q == ST_LOCKED_FULL);
    assign pick_req  = locked ? (req_valid & owner_mask) : req_valid;
    assign take_lock = req_lock[gnt_id];
`else
    logic unused_lock;

    assign full        = (state_q == ST_FULL);
    assign pick_req    = req_valid;
    assign unused_lock = ^req_lock;
`endif

    rr_pick #(
        .REQN (REQN),
        .IDW  (IDW)
    ) u_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .grant  (grant),
        .gnt_id (gnt_id),
        .any    (pick_any)
    );

    alu #(
        .N (N)
    ) u_alu (
        .op     (op_v[gnt_id]),
        .lhs    (lhs_v[gnt_id]),
        .rhs    (rhs_v[gnt_id]),
        .result (alu_y)
    );

    // The slot can take a new op if empty or if it is being drained now.
    assign slot_free = !full || rsp_ready;
    assign accept    = pick_any && slot_free;
    assign ptr_inc   = (gnt_id == IDW'(REQN - 1)) ? '0 : gnt_id + 1'b1;

    // Ready is masked during reset so no handshake can complete then.
    assign req_ready  = grant & {REQN{slot_free && !rst}};
    assign rsp_valid  = full;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign busy       = full || (|req_valid);

    // Next-state: load on accept, otherwise empty the slot when drained.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        result_d = result_q;
        if (accept) begin
            id_d     = gnt_id;
            result_d = alu_y;
`ifdef ALU_ARB_LOCK_EN
            if (take_lock) begin
                state_d = ST_LOCKED_FULL;
                ptr_d   = gnt_id;
            end else begin
                state_d = ST_FULL;
                ptr_d   = ptr_inc;
            end
`else
            state_d = ST_FULL;
            ptr_d   = ptr_inc;
`endif
        end else if (full && rsp_ready) begin
`ifdef ALU_ARB_LOCK_EN
            state_d = locked ? ST_LOCKED_EMPTY : ST_EMPTY;
`else
            state_d = ST_EMPTY;
`endif
        end
    end

    // State, pointer and response registers; reset discards any response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            ptr_q    <= '0;
            id_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural arbitration model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 16;
    localparam int REQN = 4;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [REQN-1:0]     req_valid, req_ready, req_lock;
    logic [3*REQN-1:0]   req_op;
    logic [N*REQN-1:0]   req_lhs, req_rhs;
    logic                rsp_valid, rsp_ready, busy;
    logic [IDW-1:0]      rsp_id;
    logic [N-1:0]        rsp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N), .REQN(REQN), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_lhs    (req_lhs),
        .req_rhs    (req_rhs),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    // Requester-side pending requests.
    bit         pv  [REQN];
    logic [2:0] pop [REQN];
    logic [N-1:0] pl [REQN];
    logic [N-1:0] pr [REQN];
    bit         plk [REQN];

    // Reference model state.
    int         m_ptr;
    bit         m_full;
    bit         m_lock;
    int         m_id;
    logic [N-1:0] m_res;

    int n_chk  = 0;
    int n_fail = 0;
    logic [REQN-1:0] obs_ready;
    int last_w;

    always_comb begin
        req_valid = '0;
        req_lock  = '0;
        req_op    = '0;
        req_lhs   = '0;
        req_rhs   = '0;
        for (int i = 0; i < REQN; i++) begin
            req_valid[i]       = pv[i];
            req_lock[i]        = plk[i];
            req_op[3*i +: 3]   = pop[i];
            req_lhs[N*i +: N]  = pl[i];
            req_rhs[N*i +: N]  = pr[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] alu_ref(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[3:0];
            3'd6: r = a >> b[3:0];
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic int model_winner();
        if (m_lock) return pv[m_ptr] ? m_ptr : -1;
        for (int k = 0; k < REQN; k++) begin
            int j;
            j = (m_ptr + k) % REQN;
            if (pv[j]) return j;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [REQN-1:0] r);
        for (int i = 0; i < REQN; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 1'b0;
        m_lock = 1'b0;
        m_id   = 0;
        m_res  = '0;
    endtask

    task automatic new_req(input int i, input bit lk);
        pv[i]  = 1'b1;
        pop[i] = 3'($urandom_range(0, 7));
        pl[i]  = N'($urandom);
        pr[i]  = N'($urandom);
        plk[i] = lk;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < REQN; i++) begin
            pv[i]  = 1'b0;
            plk[i] = 1'b0;
        end
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic step();
        int w;
        bit free;
        bit anyv;
        logic [REQN-1:0] er;
        @(negedge clk);
        w    = model_winner();
        free = !m_full || rsp_ready;
        er   = '0;
        if (w >= 0 && free) er[w] = 1'b1;
        anyv = 1'b0;
        for (int i = 0; i < REQN; i++) anyv |= pv[i];
        obs_ready = req_ready;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, m_full);
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_result", rsp_result, m_res);
        chk("busy", busy, m_full || anyv);
        $display("t=%0t ready=%b rsp_valid=%b id=%0d result=%h", $time, req_ready, rsp_valid, rsp_id, rsp_result);
        @(posedge clk);
        #1;
        if (w >= 0 && free) begin
            m_res  = alu_ref(pop[w], pl[w], pr[w]);
            m_id   = w;
            m_full = 1'b1;
`ifdef ALU_ARB_LOCK_EN
            m_lock = plk[w];
            m_ptr  = plk[w] ? w : (w + 1) % REQN;
`else
            m_ptr  = (w + 1) % REQN;
`endif
            pv[w]  = 1'b0;
            last_w = w;
        end else begin
            last_w = -1;
            if (m_full && rsp_ready) m_full = 1'b0;
        end
    endtask

    task automatic reset_checks();
        chk("rst_ready", req_ready, '0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_id", rsp_id, '0);
        chk("rst_result", rsp_result, '0);
        chk("rst_busy", busy, |req_valid);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq1 [5] = '{0, 1, 2, 3, 0};
        int exp_lock [4];
        int k1;
        logic [REQN-1:0] one;
`ifdef ALU_ARB_LOCK_EN
        exp_lock = '{1, 1, 1, 0};
`else
        exp_lock = '{1, 0, 1, 0};
`endif
        one = 1;

        // Reset held with all requesters valid.
        rst = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < REQN; i++) new_req(i, 1'b0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            reset_checks();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin order 0,1,2,3,0 with all requesters continuously valid.
        rsp_ready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("rr_order", obs_ready, one << seq1[s]);
            if (last_w >= 0) new_req(last_w, 1'b0);
        end
        clear_reqs();
        step();

        // ADD wraps: FFFF + 2 = 0001 from requester 2.
        pv[2] = 1'b1; pop[2] = ALU_ADD; pl[2] = 16'hFFFF; pr[2] = 16'h0002; plk[2] = 1'b0;
        step();
        chk("add_ready", obs_ready, 4'b0100);
        chk("add_valid", rsp_valid, 1'b1);
        chk("add_id", rsp_id, 2'd2);
        chk("add_result", rsp_result, 16'h0001);
        step();

        // SUB 3-5 under 3 cycles of backpressure, then drain + accept.
        rsp_ready = 1'b0;
        pv[1] = 1'b1; pop[1] = ALU_SUB; pl[1] = 16'h0003; pr[1] = 16'h0005; plk[1] = 1'b0;
        step();
        new_req(0, 1'b0);
        repeat (3) begin
            step();
            chk("bp_ready", obs_ready, '0);
            chk("bp_result", rsp_result, 16'hFFFE);
            chk("bp_id", rsp_id, 2'd1);
        end
        rsp_ready = 1'b1;
        step();
        chk("drain_accept", obs_ready, 4'b0001);
        chk("drain_valid", rsp_valid, 1'b1);
        step();

        // Wrap-around: ptr=3 with requesters 0 and 3 valid.
        new_req(2, 1'b0);
        step();
        new_req(0, 1'b0);
        new_req(3, 1'b0);
        step();
        chk("wrap_first", obs_ready, 4'b1000);
        step();
        chk("wrap_second", obs_ready, 4'b0001);
        step();

        // Asynchronous reset while a response is held.
        rsp_ready = 1'b0;
        new_req(1, 1'b0);
        step();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", rsp_valid, 1'b0);
        model_reset();
        new_req(1, 1'b0);
        new_req(3, 1'b0);
        @(negedge clk);
        reset_checks();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("post_rst_grant", obs_ready, 4'b0010);
        clear_reqs();
        step();

        // Lock scenario: move ptr to 1, then requester 1 issues lock=1,1,0.
        new_req(0, 1'b0);
        step();
        new_req(0, 1'b0);
        new_req(1, 1'b1);
        k1 = 1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk("lock_seq", onehot_idx(obs_ready), exp_lock[s]);
            if (last_w == 1 && k1 < 3) begin
                new_req(1, k1 < 2);
                k1++;
            end else if (last_w == 0) begin
                new_req(0, 1'b0);
            end
        end
        clear_reqs();
        step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < REQN; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) new_req(i, $urandom_range(0, 3) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
